// File: rtl/qeciphy_tx_framer.sv
// rtl/qeciphy_tx_framer.sv - GTX TX framer: comma alignment burst, payload/idle words, periodic comma.
// Optional statistics counters enabled by QECIPHY_TX_FRAMER_STATS_EN.
module qeciphy_tx_framer #(
  parameter int COMMA_PERIOD = 1024,
  parameter int ALIGN_WORDS  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_enable,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] gt_txdata,
  output logic [3:0]  gt_txcharisk,
  output logic        align_done,
  output logic [31:0] stat_data_cnt,
  output logic [31:0] stat_comma_cnt
);

  localparam logic [31:0] COMMA_WORD = 32'h4A4A4ABC;
  localparam logic [31:0] IDLE_WORD  = 32'h4A4A4A1C;
  localparam int CW = ($clog2(COMMA_PERIOD) < 1) ? 1 : $clog2(COMMA_PERIOD);
  localparam int AW = ($clog2(ALIGN_WORDS) < 1) ? 1 : $clog2(ALIGN_WORDS);
  localparam logic [CW-1:0] COMMA_LAST = CW'(COMMA_PERIOD - 1);
  localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_WORDS - 1);

  typedef enum logic [1:0] {ST_OFF, ST_ALIGN, ST_DATA} state_t;

  state_t        state, next_state;
  logic [AW-1:0] align_cnt, next_align;
  logic [CW-1:0] comma_cnt, next_comma;
  logic [31:0]   next_data;
  logic [3:0]    next_k;
  logic          comma_due;

  assign comma_due = (comma_cnt == COMMA_LAST);
  // Gated by tx_enable so nothing is accepted on the cycle the link is being torn down.
  assign s_axis_tready = tx_enable && (state == ST_DATA) && !comma_due;

  always_comb begin
    next_state = state;
    next_align = align_cnt;
    next_comma = comma_cnt;
    next_data  = COMMA_WORD;
    next_k     = 4'b0001;
    if (!tx_enable) begin
      next_state = ST_OFF;
      next_align = '0;
      next_comma = '0;
    end else begin
      case (state)
        // The comma emitted on the enabling edge is the first word of the burst.
        ST_OFF: begin
          if (ALIGN_WORDS == 1) begin
            next_state = ST_DATA;
          end else begin
            next_state = ST_ALIGN;
            next_align = AW'(1);
          end
        end
        ST_ALIGN: begin
          if (align_cnt == ALIGN_LAST) begin
            next_state = ST_DATA;
            next_align = '0;
          end else begin
            next_align = align_cnt + AW'(1);
          end
        end
        ST_DATA: begin
          if (comma_due) begin
            next_comma = '0;
          end else begin
            next_comma = comma_cnt + CW'(1);
            if (s_axis_tvalid) begin
              next_data = s_axis_tdata;
              next_k    = 4'b0000;
            end else begin
              next_data = IDLE_WORD;
            end
          end
        end
        default: next_state = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_OFF;
      align_cnt    <= '0;
      comma_cnt    <= '0;
      gt_txdata    <= COMMA_WORD;
      gt_txcharisk <= 4'b0001;
      align_done   <= 1'b0;
    end else begin
      state        <= next_state;
      align_cnt    <= next_align;
      comma_cnt    <= next_comma;
      gt_txdata    <= next_data;
      gt_txcharisk <= next_k;
      align_done   <= tx_enable && (state == ST_DATA);
    end
  end

`ifdef QECIPHY_TX_FRAMER_STATS_EN
  logic [31:0] data_cnt_q, comma_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_cnt_q  <= '0;
      comma_cnt_q <= '0;
    end else begin
      if (next_k == 4'b0000) data_cnt_q <= data_cnt_q + 32'd1;
      if (next_k == 4'b0001 && next_data[7:0] == 8'hBC) comma_cnt_q <= comma_cnt_q + 32'd1;
    end
  end

  assign stat_data_cnt  = data_cnt_q;
  assign stat_comma_cnt = comma_cnt_q;
`else
  assign stat_data_cnt  = '0;
  assign stat_comma_cnt = '0;
`endif

endmodule

// File: tb/tb_qeciphy_tx_framer.sv
// tb/tb_qeciphy_tx_framer.sv - directed scoreboard bench for qeciphy_tx_framer (ALIGN_WORDS=4, COMMA_PERIOD=8).
module tb_qeciphy_tx_framer;
  localparam logic [31:0] COMMA = 32'h4A4A4ABC;
  localparam logic [31:0] IDLE  = 32'h4A4A4A1C;

  logic        clk;
  logic        rst_n;
  logic        tx_enable;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] gt_txdata;
  logic [3:0]  gt_txcharisk;
  logic        align_done;
  logic [31:0] stat_data_cnt;
  logic [31:0] stat_comma_cnt;

  qeciphy_tx_framer #(.COMMA_PERIOD(8), .ALIGN_WORDS(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_enable(tx_enable),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .gt_txdata(gt_txdata),
    .gt_txcharisk(gt_txcharisk),
    .align_done(align_done),
    .stat_data_cnt(stat_data_cnt),
    .stat_comma_cnt(stat_comma_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  int exp_commas = 0;
  int exp_datas = 0;
  logic [35:0] exp_q[$];
  logic [31:0] n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: drive payload, check tready, push the expected word, then pop and compare after the edge.
  task automatic step(input logic v, input logic [31:0] d, input logic [31:0] ed,
                      input logic [3:0] ek, input logic exp_rdy);
    logic [35:0] e;
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    #1;
    check("tready", {31'd0, s_axis_tready}, {31'd0, exp_rdy});
    exp_q.push_back({ed, ek});
    if (ek == 4'b0001 && ed == COMMA) exp_commas++;
    if (ek == 4'b0000) exp_datas++;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("txdata", gt_txdata, e[35:4]);
    check("txcharisk", {28'd0, gt_txcharisk}, {28'd0, e[3:0]});
  endtask

  task automatic check_stats(input string tag);
`ifdef QECIPHY_TX_FRAMER_STATS_EN
    check({tag, "_comma"}, stat_comma_cnt, exp_commas);
    check({tag, "_data"}, stat_data_cnt, exp_datas);
`else
    check({tag, "_comma"}, stat_comma_cnt, 32'd0);
    check({tag, "_data"}, stat_data_cnt, 32'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    tx_enable = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txdata", gt_txdata, COMMA);
    check("rst_charisk", {28'd0, gt_txcharisk}, 32'd1);
    check("rst_align_done", {31'd0, align_done}, 32'd0);
    check("rst_tready", {31'd0, s_axis_tready}, 32'd0);
    check_stats("rst_stat");

    // Alignment burst: enable present when reset releases.
    tx_enable = 1'b1;
    rst_n = 1'b1;
    repeat (4) step(1'b0, '0, COMMA, 4'b0001, 1'b0);
    check("align_done_last_comma", {31'd0, align_done}, 32'd0);

    // Full tvalid: 7 data, comma (word held), 7 data, comma.
    n = 32'd1;
    for (int i = 1; i <= 16; i++) begin
      if (i % 8 == 0) step(1'b1, n, COMMA, 4'b0001, 1'b0);
      else begin
        step(1'b1, n, n, 4'b0000, 1'b1);
        n = n + 32'd1;
      end
      if (i == 1) check("align_done_data", {31'd0, align_done}, 32'd1);
    end
`ifdef QECIPHY_TX_FRAMER_STATS_EN
    check("stat_comma_6", stat_comma_cnt, 32'd6);
    check("stat_data_14", stat_data_cnt, 32'd14);
`else
    check("stat_comma_off", stat_comma_cnt, 32'd0);
    check("stat_data_off", stat_data_cnt, 32'd0);
`endif

    // Toggling tvalid: data and idle interleave, comma still every 8th word.
    for (int i = 0; i < 16; i++) begin
      if (i % 8 == 7) step(1'b0, '0, COMMA, 4'b0001, 1'b0);
      else if (i % 2 == 0) begin
        step(1'b1, n, n, 4'b0000, 1'b1);
        n = n + 32'd1;
      end else step(1'b0, '0, IDLE, 4'b0001, 1'b1);
    end

    // Drop tx_enable mid-DATA with a word pending, then re-align.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, n, n, 4'b0000, 1'b1);
      n = n + 32'd1;
    end
    tx_enable = 1'b0;
    step(1'b1, n, COMMA, 4'b0001, 1'b0);
    check("align_done_drop", {31'd0, align_done}, 32'd0);
    step(1'b1, n, COMMA, 4'b0001, 1'b0);
    tx_enable = 1'b1;
    repeat (4) step(1'b1, n, COMMA, 4'b0001, 1'b0);
    step(1'b1, n, n, 4'b0000, 1'b1);
    check("align_done_reenable", {31'd0, align_done}, 32'd1);
    n = n + 32'd1;
    step(1'b0, '0, IDLE, 4'b0001, 1'b1);
    check_stats("stat_mid");

    // Asynchronous reset in the middle of ALIGN.
    tx_enable = 1'b0;
    step(1'b0, '0, COMMA, 4'b0001, 1'b0);
    tx_enable = 1'b1;
    step(1'b0, '0, COMMA, 4'b0001, 1'b0);
    step(1'b0, '0, COMMA, 4'b0001, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    exp_commas = 0;
    exp_datas = 0;
    check("arst_txdata", gt_txdata, COMMA);
    check("arst_charisk", {28'd0, gt_txcharisk}, 32'd1);
    check("arst_align_done", {31'd0, align_done}, 32'd0);
    check("arst_tready", {31'd0, s_axis_tready}, 32'd0);
    check_stats("arst_stat");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) step(1'b0, '0, COMMA, 4'b0001, 1'b0);
    step(1'b0, '0, IDLE, 4'b0001, 1'b1);
    check("align_done_after_rst", {31'd0, align_done}, 32'd1);
    check_stats("stat_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/qeciphy_tx_framer.md
Name: qeciphy_tx_framer

Overview:
- TX-side fabric framer driving the GTX parallel transmit interface (txdata 32-bit, txcharisk 4-bit) on the txusrclk2 domain.
- Accepts a 32-bit valid/ready payload stream.
- Emits an alignment burst of comma words after the TX reset FSM completes, then payload words, idle words when no payload is offered, and a periodic comma word so the far-end receiver keeps byte alignment (rxbyteisaligned).
- Counterpart of the receive path's comma detection and word alignment.

Parameters:
- COMMA_PERIOD, 1024, words between forced comma insertions in DATA state (legal range ≥ 2).
- ALIGN_WORDS, 64, number of consecutive comma words sent in ALIGN state (legal range ≥ 1).

Ports:
- clk  input  1  txusrclk2-domain clock.
- rst_n  input  1  reset; asynchronous, active-low.
- tx_enable  input  1  high once the transceiver TX reset FSM is done; level-sensitive.
- s_axis_tdata  input  32  payload word.
- s_axis_tvalid  input  1  payload valid.
- s_axis_tready  output  1  framer accepts the payload word this cycle.
- gt_txdata  output  32  to transceiver txdata.
- gt_txcharisk  output  4  to transceiver txcharisk; bit i flags byte i as a K-char.
- align_done  output  1  high while in DATA state.
- stat_data_cnt  output  32  payload words transmitted (see Optional Feature).
- stat_comma_cnt  output  32  comma words transmitted (see Optional Feature).

Behaviour:
- Word encodings, byte 0 is the LSB:
  - COMMA = 32'h4A4A4ABC with charisk 4'b0001 (K28.5 followed by D10.2).
  - IDLE = 32'h4A4A4A1C with charisk 4'b0001 (K28.0 followed by D10.2).
  - DATA = s_axis_tdata with charisk 4'b0000.
- gt_txdata, gt_txcharisk, align_done and the stat counters are registered outputs.
- Reset values: gt_txdata = COMMA, gt_txcharisk = 4'b0001, align_done = 0, stat counters = 0, state = OFF.
- States:
  - OFF: output COMMA every cycle. Go to ALIGN when tx_enable = 1.
  - ALIGN: output COMMA every cycle and count. After exactly ALIGN_WORDS comma words, go to DATA, with align_done = 1 from the cycle the first DATA-state word is presented.
  - DATA: comma_cnt counts words emitted since the last COMMA.
    - When comma_cnt == COMMA_PERIOD-1, the next word is COMMA and comma_cnt resets to 0.
    - Otherwise the next word is DATA if the handshake occurs, else IDLE.
- s_axis_tready is combinational: 1 only in DATA state when a comma is not due. It is 0 in OFF and ALIGN.
- A transfer occurs when tvalid && tready. The accepted word appears on gt_txdata on the next clock edge, so latency is 1 cycle.
- tvalid held high with tready = 0 keeps the word pending; the upstream source must hold tdata stable.
- Comma spacing in DATA is exactly COMMA_PERIOD words (one COMMA followed by COMMA_PERIOD-1 DATA/IDLE words), independent of payload traffic.
- The first comma insertion is counted from DATA entry, with comma_cnt = 0 at entry.
- tx_enable falling in any state:
  - Next cycle: state = OFF, align_done = 0, tready = 0, output COMMA.
  - The ALIGN and comma counters clear.
  - Words not accepted are not transmitted and are not lost by the framer; upstream still holds them.
- tx_enable re-asserting: the full ALIGN burst repeats.
- rst_n asserted mid-operation: all state returns to reset values immediately (asynchronous).
- Counter widths: $clog2 of the respective parameter, minimum 1 bit. Counters wrap only by explicit reset to 0, never by overflow.

Optional Feature:
- Macro: QECIPHY_TX_FRAMER_STATS_EN.
- Defined:
  - stat_data_cnt increments by 1 on every DATA word emitted.
  - stat_comma_cnt increments by 1 on every COMMA word emitted in any state.
  - Both are 32-bit and wrap modulo 2^32.
  - Both clear only on rst_n, not on tx_enable low.
- Undefined: both outputs are tied to 0 and no counter logic is instantiated.

Test Plan:
- Reset, then tx_enable=1 with ALIGN_WORDS=4 and COMMA_PERIOD=8 → 4 COMMA words, then align_done=1, tready=1, IDLE words (32'h4A4A4A1C, charisk 4'b0001).
- DATA state, tvalid=1 continuously, tdata incrementing from 32'h00000001 → outputs data 1..7 with charisk 0, then COMMA with tready=0 that cycle, then data 8 (held, not dropped).
- tvalid toggling 1/0 → payload and IDLE words interleave in order, and a COMMA still appears exactly every 8th word.
- tx_enable dropped mid-DATA with tvalid=1 → next cycle COMMA, tready=0, align_done=0. Re-enable → 4 more COMMA words before data resumes with the pending word.
- rst_n pulsed low mid-ALIGN → outputs immediately return to COMMA/4'b0001, align_done=0, and the stat counters read 0.
- With QECIPHY_TX_FRAMER_STATS_EN: after the first scenario plus 16 DATA-state words at full tvalid → stat_comma_cnt=6, stat_data_cnt=14. Without the macro, both read 0.
